// File: rtl/and3_vector_checker.sv
// and3_vector_checker
//
// Exhaustively exercises a 3-input combinational gate-under-test. The eight
// input vectors are applied in ascending order, idx = {c, b, a}. Each vector
// is held for SETTLE_CYCLES cycles and then sampled for one cycle. The
// gate's response y is compared with TRUTH_TABLE[idx].
//
// Parameters
//   TRUTH_TABLE    expected y for vector i at bit i (default: 3-input AND)
//   SETTLE_CYCLES  drive cycles per vector before sampling (1..15)
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   start          one-cycle run request, accepted only in IDLE or DONE
//   y              gate-under-test output, looked at only in SAMPLE
//   a, b, c        registered stimulus to the gate-under-test
//   busy           high in DRIVE and SAMPLE
//   done           high in DONE only
//   pass           high in DONE only when no vector mismatched
//   err_count      number of mismatching vectors in the current run (0..8)
//   first_err_idx  index of the first mismatching vector of the run
//   err_seen       high once any mismatch has been recorded in the run
//   state_dbg      current FSM state (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//
// Handshake: start is a single-cycle request with no acknowledge. It is
// taken at a rising edge only when busy is low, and it is dropped silently
// otherwise. The outcome of a run is valid for as long as done is high.
module and3_vector_checker #(
    parameter logic [7:0] TRUTH_TABLE   = 8'b1000_0000,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err_idx,
    output logic       err_seen,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Value of the settle counter on the final DRIVE cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] err_count_q, err_count_d;
    logic [2:0] first_err_idx_q, first_err_idx_d;
    logic       err_seen_q, err_seen_d;
    logic       mismatch;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        settle_d        = settle_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        err_seen_d      = err_seen_q;
        mismatch        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A new run clears every result of the previous one.
                if (start) begin
                    state_d         = S_DRIVE;
                    idx_d           = 3'd0;
                    settle_d        = 4'd0;
                    err_count_d     = 4'd0;
                    first_err_idx_d = 3'd0;
                    err_seen_d      = 1'b0;
                end
            end

            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                mismatch = (y != TRUTH_TABLE[idx_q]);
                if (mismatch) begin
                    // At most 8 samples per run, so a 4-bit count cannot wrap.
                    err_count_d = err_count_q + 4'd1;
                    if (!err_seen_q) begin
                        first_err_idx_d = idx_q;
                        err_seen_d      = 1'b1;
                    end
                end
                if (idx_q == 3'd7) begin
                    // idx remains at 7, so a/b/c keep showing the last vector.
                    state_d = S_DONE;
                end else begin
                    state_d  = S_DRIVE;
                    idx_d    = idx_q + 3'd1;
                    settle_d = 4'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            idx_q           <= 3'd0;
            settle_q        <= 4'd0;
            err_count_q     <= 4'd0;
            first_err_idx_q <= 3'd0;
            err_seen_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            settle_q        <= settle_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            err_seen_q      <= err_seen_d;
        end
    end

    // The stimulus is the vector index register itself. It is zero in IDLE,
    // it is stable through DRIVE and SAMPLE, and it holds 3'b111 in DONE.
    assign a = idx_q[0];
    assign b = idx_q[1];
    assign c = idx_q[2];

    assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign pass          = (state_q == S_DONE) && (err_count_q == 4'd0);
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign err_seen      = err_seen_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_and3_vector_checker.sv
// Testbench for and3_vector_checker (default parameters).
// Gate models on y: 0 = correct AND3, 1 = stuck at 0, 2 = stuck at 1,
// 3 = AND3 with the output inverted for vector 2 only.
module tb_and3_vector_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;
    logic       err_seen;
    logic [1:0] state_dbg;

    int mode;
    int cyc;
    int checks;
    int errors;

    // Expected run result packed as {pass, err_count, first_err_idx, err_seen}.
    logic [8:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [2:0] vec_q[$];

    and3_vector_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .y            (y),
        .a            (a),
        .b            (b),
        .c            (c),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_err_idx(first_err_idx),
        .err_seen     (err_seen),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- gate-under-test model ----------------
    always_comb begin
        y = 1'b0;
        case (mode)
            0: y = a & b & c;
            1: y = 1'b0;
            2: y = 1'b1;
            3: y = (a & b & c) ^ ({c, b, a} == 3'd2);
            default: y = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic done_prev;
    initial done_prev = 1'b0;

    always @(negedge clk) begin
        // Each SAMPLE cycle must present the next vector in the expected order.
        if (!rst && state_dbg == 2'd2) begin
            if (vec_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vec_unexpected: got %0d expected none", {c, b, a});
            end else begin
                check("vec_order", {c, b, a}, vec_q.pop_front());
            end
        end
        // The rising edge of done ends a run: compare its result and latency.
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected done=0");
            end else begin
                check("run_result", {pass, err_count, first_err_idx, err_seen}, exp_q.pop_front());
                check("done_latency", cyc - exp_cyc_q.pop_front(), 24);
            end
        end
        done_prev <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        check({tag, "_abc"}, {c, b, a}, 3'b000);
        check({tag, "_flags"}, {busy, done, pass}, 3'b000);
        check({tag, "_counters"}, {err_count, first_err_idx, err_seen}, 8'h00);
        check({tag, "_state"}, state_dbg, 2'd0);
    endtask

    task automatic wait_cond_abc(input logic [2:0] v, input bit need_sample, input string tag);
        int n;
        n = 0;
        while (!({c, b, a} == v && (!need_sample || state_dbg == 2'd2)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no vector %0d expected it within 100 cycles", tag, v);
        end
    endtask

    task automatic run_vectors(input int m, input logic [8:0] exp_res, input bit pulse_mid);
        int n;
        mode = m;
        for (int i = 0; i < 8; i++) vec_q.push_back(3'(i));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(exp_res);
        exp_cyc_q.push_back(cyc);
        check("accept_clear", {busy, err_count, first_err_idx, err_seen}, 9'h100);
        if (pulse_mid) begin
            wait_cond_abc(3'd3, 1'b0, "mid_start");
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 100 cycles");
        end
        repeat (3) @(negedge clk);
        check("done_hold", {done, pass, err_count, first_err_idx, err_seen, c, b, a},
              {1'b1, exp_res, 3'b111});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        mode   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Correct AND3: every vector matches.
        run_vectors(0, {1'b1, 4'd0, 3'd0, 1'b0}, 1'b0);
        // Stuck at 0: only vector 7 (expected 1) mismatches.
        run_vectors(1, {1'b0, 4'd1, 3'd7, 1'b1}, 1'b0);
        // Restart from DONE with a correct gate, plus a start pulse at idx 3 that must be ignored.
        run_vectors(0, {1'b1, 4'd0, 3'd0, 1'b0}, 1'b1);
        // Stuck at 1: vectors 0..6 mismatch.
        run_vectors(2, {1'b0, 4'd7, 3'd0, 1'b1}, 1'b0);
        // Single fault on vector 2.
        run_vectors(3, {1'b0, 4'd1, 3'd2, 1'b1}, 1'b0);

        // rst and start asserted together from DONE: rst takes priority.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_idle("rst_prio");

        // Reset during SAMPLE of idx 4 after one recorded error (vector 2).
        mode = 3;
        for (int i = 0; i < 8; i++) vec_q.push_back(3'(i));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cond_abc(3'd4, 1'b1, "sample4");
        check("err_before_rst", {err_count, first_err_idx, err_seen}, {4'd1, 3'd2, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec_q.delete();
        check_idle("mid_rst");
        repeat (30) @(negedge clk);
        check("no_auto_restart", {state_dbg, done, busy}, 4'b0000);

        // A fresh start is needed after the reset and produces a clean run.
        run_vectors(0, {1'b1, 4'd0, 3'd0, 1'b0}, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size() + vec_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
